ex_muldiv_ctrl: RTL and testbench

Sequencer for the shared iterative multiply/divide unit in the EX stage of the pipelined RV32 core. It accepts an M-extension instruction sitting in EX, runs a fixed-length shift-add / restoring-divide sequence, and holds the front of the pipeline via a stall request to the hazard unit until the result is ready. It delivers the result for exactly one cycle, as the instruction advances to MEM.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_iter_dp.sv | 76 +++++++
 rtl/ex_muldiv_ctrl.sv | 149 ++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit.
// Holds the operand width, the M-extension funct3 encodings, the sequencer
// state type and the RISC-V special-case quotient constants.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;

  localparam logic [XLEN-1:0] DIV0_Q = '1;
  localparam logic [XLEN-1:0] OVF_Q  = {1'b1, {(XLEN-1){1'b0}}};

  // funct3[2] separates the divide/remainder group from the multiplies
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iteration datapath: one shift-add multiply step or one restoring-divide
// step per cycle on unsigned magnitudes.
// Ports: clk, rst (sync, active high); load captures a_mag/b_mag and mode;
// step advances one iteration; acc_hi/acc_lo expose the 2*XLEN accumulator
// (product high/low, or remainder/quotient).
module muldiv_iter_dp
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] acc_hi,
  output logic [XLEN-1:0] acc_lo
);

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            div_q, div_d;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_diff;

  // lo holds multiplier bits (shifted out) or dividend bits (quotient shifted in)
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {hi_q, lo_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (load) begin
      hi_d   = '0;
      lo_d   = a_mag;
      opnd_d = b_mag;
      div_d  = is_div;
    end else if (step) begin
      if (div_q) begin
        // borrow in the top bit means the trial subtract failed: restore
        if (!rem_diff[XLEN]) begin
          hi_d = rem_diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = rem_sh[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
    end
  end

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: accepts an M-extension op, runs XLEN
// iterations in muldiv_iter_dp, applies sign correction and RISC-V special
// cases, and stalls the front of the pipe until the result is ready.
// Ports: clk, rst (sync, active high); start_e/op_e/a_e/b_e from EX;
// flush_e aborts; stall_req to hazard unit; done/result valid one cycle.
module ex_muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_e,
  input  logic [2:0]      op_e,
  input  logic [XLEN-1:0] a_e,
  input  logic [XLEN-1:0] b_e,
  input  logic            flush_e,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [XLEN-1:0]    result_q, result_d;

  logic               a_neg, b_neg, res_neg;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic               div0, ovf, special;
  logic [XLEN-1:0]    special_res;
  logic               dp_load, dp_step;
  logic [XLEN-1:0]    dp_hi, dp_lo;
  logic [2*XLEN-1:0]  prod_fix;
  logic [XLEN-1:0]    div_sel, fix_res;

  // Operand signedness, magnitudes, result sign and special-case detection
  always_comb begin
    a_neg   = a_e[XLEN-1] & ((op_e == OP_MULH) | (op_e == OP_MULHSU) |
                             (op_e == OP_DIV)  | (op_e == OP_REM));
    b_neg   = b_e[XLEN-1] & ((op_e == OP_MULH) | (op_e == OP_DIV) |
                             (op_e == OP_REM));
    a_mag   = a_neg ? -a_e : a_e;
    b_mag   = b_neg ? -b_e : b_e;
    // remainder follows the dividend; product/quotient follow the xor
    res_neg = (op_e == OP_REM) | (op_e == OP_MULHSU) ? a_neg : (a_neg ^ b_neg);
    div0    = is_div_op(op_e) & (b_e == '0);
    // funct3[0] clear in the divide group means signed
    ovf     = is_div_op(op_e) & ~op_e[0] & (a_e == OVF_Q) & (b_e == '1);
    special = div0 | ovf;
    if (div0) special_res = op_e[1] ? a_e : DIV0_Q;
    else      special_res = op_e[1] ? '0  : OVF_Q;
  end

  // Sign correction and half/quotient/remainder selection for FIX
  always_comb begin
    prod_fix = neg_q ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
    div_sel  = op_q[1] ? dp_hi : dp_lo;
    if (is_div_op(op_q))     fix_res = neg_q ? -div_sel : div_sel;
    else if (op_q == OP_MUL) fix_res = prod_fix[XLEN-1:0];
    else                     fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_e) begin
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            dp_load = 1'b1;
            cnt_d   = '0;
            op_d    = op_e;
            neg_d   = res_neg;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!start_e) begin
          state_d = IDLE;
        end else begin
          dp_step = 1'b1;
          cnt_d   = CNT_W'(cnt_q + 1'b1);
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (!start_e) begin
          state_d = IDLE;
        end else begin
          result_d = fix_res;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // flush beats any start or progress
    if (flush_e) begin
      state_d  = IDLE;
      dp_load  = 1'b0;
      dp_step  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  muldiv_iter_dp u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (dp_load),
    .step   (dp_step),
    .is_div (is_div_op(op_e)),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc_hi (dp_hi),
    .acc_lo (dp_lo)
  );

  // stall is combinational so the first EX cycle already holds the pipe
  assign stall_req = start_e & (state_q != DONE) & ~flush_e;
  assign done      = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed plan vectors, random ops
// against an arithmetic reference model, flush/abort/reset and back-to-back.
module tb_ex_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_e = 1'b0;
  logic [2:0]  op_e = 3'b000;
  logic [31:0] a_e = '0;
  logic [31:0] b_e = '0;
  logic        flush_e = 1'b0;
  logic        stall_req;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start_e   (start_e),
    .op_e      (op_e),
    .a_e       (a_e),
    .b_e       (b_e),
    .flush_e   (flush_e),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  // Reference: plain 64-bit arithmetic plus the RISC-V special cases
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      OP_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      OP_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      OP_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      OP_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      OP_DIVU: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      default: begin
        if (b == 32'h0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 34;
  endfunction

  // Presents an op at cycle t and holds it until done is seen (bounded);
  // returns with start_e still high in the DONE cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat, output int stalls);
    @(negedge clk);
    start_e = 1'b1; op_e = op; a_e = a; b_e = b; flush_e = 1'b0;
    lat = -1; stalls = 0; res = '0;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (stall_req) stalls++;
      if (done) begin
        lat = i;
        res = result;
        break;
      end
    end
  endtask

  // Instruction leaves EX; operands change to show the output does not follow them
  task automatic release_op();
    @(negedge clk);
    start_e = 1'b0; a_e = $urandom; b_e = $urandom;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_e = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall_idle got=%b want=0", stall_req); end
    start_e = 1'b1;
    #1;
    total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL reset_stall_start got=%b want=1", stall_req); end
    @(negedge clk);
    start_e = 1'b0; rst = 1'b0;
  endtask

  logic [2:0]  d_op  [12] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
                             OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
  logic [31:0] d_a   [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                             32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
  int          d_lat [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};

  task automatic test_directed();
    logic [31:0] res;
    int lat, stalls;
    for (int i = 0; i < 12; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], res, lat, stalls);
      total++; if (res !== d_exp[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, d_exp[i]); end
      total++; if (lat !== d_lat[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, d_lat[i]); end
      total++; if (stalls !== d_lat[i]) begin bad++; $display("FAIL dir%0d_stalls got=%0d want=%0d", i, stalls, d_lat[i]); end
      release_op();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL dir%0d_done_width got=%b want=0", i, done); end
      total++; if (result !== d_exp[i]) begin bad++; $display("FAIL dir%0d_hold got=%h want=%h", i, result, d_exp[i]); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res, exp;
    int lat, stalls, pick;
    for (int i = 0; i < 24; i++) begin
      op   = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      pick = $urandom_range(0, 7);
      if (pick == 0) b = 32'h0;
      else if (pick == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (pick == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
      else if (pick == 3) b = 32'($urandom_range(1, 255)) | 32'hFFFF_FF00;
      exp = ref_result(op, a, b);
      run_op(op, a, b, res, lat, stalls);
      total++; if (res !== exp) begin bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, res, exp); end
      total++; if (lat !== ref_latency(op, a, b)) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, ref_latency(op, a, b)); end
      total++; if (stalls !== ref_latency(op, a, b)) begin bad++; $display("FAIL rnd%0d_stalls got=%0d want=%0d", i, stalls, ref_latency(op, a, b)); end
      release_op();
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, stalls, dones;
    @(negedge clk);
    start_e = 1'b1; op_e = OP_DIVU; a_e = 32'd1000; b_e = 32'd7;
    repeat (11) @(negedge clk);
    flush_e = 1'b1;
    #1;
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", stall_req); end
    @(negedge clk);
    flush_e = 1'b0; start_e = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) dones++;
      @(negedge clk);
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL flush_no_done got=%0d want=0", dones); end
    run_op(OP_DIVU, 32'd9, 32'd3, res, lat, stalls);
    total++; if (res !== 32'd3) begin bad++; $display("FAIL flush_next_result got=%h want=3", res); end
    total++; if (lat !== 34) begin bad++; $display("FAIL flush_next_latency got=%0d want=34", lat); end
    release_op();
  endtask

  task automatic test_start_drop();
    int dones;
    @(negedge clk);
    start_e = 1'b1; op_e = OP_MUL; a_e = 32'd5; b_e = 32'd6;
    repeat (6) @(negedge clk);
    start_e = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) dones++;
      @(negedge clk);
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL drop_no_done got=%0d want=0", dones); end
    total++; if (result !== 32'd3) begin bad++; $display("FAIL drop_hold got=%h want=3", result); end
  endtask

  task automatic test_rst_fix();
    @(negedge clk);
    start_e = 1'b1; op_e = OP_MULHU; a_e = 32'hFFFF_FFFF; b_e = 32'hFFFF_FFFF;
    repeat (33) @(negedge clk);
    #1;
    total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL fix_stall got=%b want=1", stall_req); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstfix_done got=%b want=0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL rstfix_result got=%h want=0", result); end
    rst = 1'b0; start_e = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, res1, res2;
    int lat, stalls;
    a = $urandom;
    b = $urandom;
    run_op(OP_MUL, a, b, res1, lat, stalls);
    total++; if (res1 !== ref_result(OP_MUL, a, b)) begin bad++; $display("FAIL b2b_mul got=%h want=%h", res1, ref_result(OP_MUL, a, b)); end
    a = $urandom;
    b = 32'($urandom_range(1, 1000));
    run_op(OP_DIVU, a, b, res2, lat, stalls);
    total++; if (res2 !== ref_result(OP_DIVU, a, b)) begin bad++; $display("FAIL b2b_divu got=%h want=%h", res2, ref_result(OP_DIVU, a, b)); end
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d want=34", lat); end
    total++; if (stalls !== 34) begin bad++; $display("FAIL b2b_stalls got=%0d want=34", stalls); end
    release_op();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_width got=%b want=0", done); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_start_drop();
    test_rst_fix();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
